seg7_scan_display: RTL

- Parameterised successor to the slot machine's fixed 4-digit number display.
- Accepts an unsigned binary value on a load strobe and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto shared active-low segment and anode lines.
- Adds leading-zero blanking, per-digit decimal points, an overflow indication and a blink mode for win/credit displays.

---
 rtl/seg7_scan_display.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_display.sv
// Binary value -> BCD via a sequential double-dabble engine, shown on a
// time-multiplexed active-low 7-segment display with blanking, dp, overflow and blink.
module seg7_scan_display #(
   parameter int NUM_WIDTH  = 11,
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 50000,
   parameter int BLINK_DIV  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_WIDTH-1:0]  number,
   input  logic                  load,
   input  logic                  lz_blank,
   input  logic                  blink,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic [6:0]            seg_n,
   output logic                  dp_n
);
   localparam int BCD_MIN = (NUM_WIDTH * 302 + 999) / 1000 + 1;
   localparam int BCD_N   = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
   localparam int BCD_W   = 4 * BCD_N;
   localparam int DISP_W  = 4 * NUM_DIGITS;
   localparam int CNT_W   = $clog2(NUM_WIDTH + 1);
   localparam int PRE_W   = $clog2(CLK_DIV);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FRM_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WIDTH - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t                state_q, state_d;
   logic [NUM_WIDTH-1:0]  bin_q, bin_d;
   logic [NUM_WIDTH-1:0]  pend_val_q, pend_val_d;
   logic                  pend_q, pend_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
   logic [DISP_W-1:0]     disp_q, disp_d;
   logic                  ovf_q, ovf_d;
   logic                  busy_q, busy_d;

   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [FRM_W-1:0]      frm_q, frm_d;
   logic                  phase_q, phase_d;

   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [DISP_W-1:0]     disp_sh;
   logic [NUM_DIGITS-1:0] dp_sh;
   logic [6:0]            glyph;

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      disp_d     = disp_q;
      ovf_d      = ovf_q;
      bcd_adj    = bcd_q;
      for (int n = 0; n < BCD_N; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) begin
            bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
         end
      end
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = SHIFT;
               bin_d   = number;
               bcd_d   = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (load) begin
               pend_d     = 1'b1;
               pend_val_d = number;
            end
            bcd_d = {bcd_adj[BCD_W-2:0], bin_q[NUM_WIDTH-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            disp_d = bcd_q[DISP_W-1:0];
            ovf_d  = |(bcd_q >> DISP_W);
            // A load arriving now or queued earlier chains straight into the next conversion.
            if (load || pend_q) begin
               state_d = SHIFT;
               bin_d   = load ? number : pend_val_q;
               bcd_d   = '0;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_comb begin
      pre_d   = pre_q + 1'b1;
      idx_d   = idx_q;
      frm_d   = frm_q;
      phase_d = phase_q;
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (frm_q == FRM_LAST) begin
               frm_d   = '0;
               phase_d = ~phase_q;
            end else begin
               frm_d = frm_q + 1'b1;
            end
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_comb begin
      disp_sh = disp_q >> {idx_q, 2'b00};
      dp_sh   = dp_mask >> idx_q;
      case (disp_sh[3:0])
         4'd0:    glyph = 7'h40;
         4'd1:    glyph = 7'h79;
         4'd2:    glyph = 7'h24;
         4'd3:    glyph = 7'h30;
         4'd4:    glyph = 7'h19;
         4'd5:    glyph = 7'h12;
         4'd6:    glyph = 7'h02;
         4'd7:    glyph = 7'h78;
         4'd8:    glyph = 7'h00;
         4'd9:    glyph = 7'h10;
         default: glyph = 7'h7F;
      endcase
      // disp_sh holds nibbles idx..top, so all-zero means this digit is a leading zero.
      if (ovf_q) begin
         seg_d = 7'h3F;
      end else if (lz_blank && (idx_q != '0) && (disp_sh == '0)) begin
         seg_d = 7'h7F;
      end else begin
         seg_d = glyph;
      end
      an_d = ~(NUM_DIGITS'(1) << idx_q);
      dp_d = ~dp_sh[0];
      if (blink && phase_q) begin
         an_d = '1;
         dp_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         pre_q   <= '0;
         idx_q   <= '0;
         frm_q   <= '0;
         phase_q <= 1'b0;
         an_q    <= '1;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         frm_q   <= frm_d;
         phase_q <= phase_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   always_ff @(posedge clk) begin
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      pend_val_q <= pend_val_d;
   end

   assign busy  = busy_q;
   assign an_n  = an_q;
   assign seg_n = seg_q;
   assign dp_n  = dp_q;
endmodule
